// File: rtl/seg7_scan_driver_if.sv
// Display-data bus between the top-level data selector and the 7-segment scan driver.
// The master drives the data and mode; the slave (the driver) returns the segment and anode signals.
interface seg7_scan_driver_if;
   logic        display_mode;
   logic [63:0] i_data;
   logic [7:0]  o_seg;
   logic [7:0]  o_sel;
   logic        o_frame_done;

   modport master (
      output display_mode,
      output i_data,
      input  o_seg,
      input  o_sel,
      input  o_frame_done
   );

   modport slave (
      input  display_mode,
      input  i_data,
      output o_seg,
      output o_sel,
      output o_frame_done
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display, latching the data bus once per frame.
// Optional leading-zero blanking in hex mode is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
   parameter int SCAN_DIV = 50000
) (
   input logic                clk,
   input logic                reset,
   seg7_scan_driver_if.slave  bus
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

   typedef enum logic {
      BLANK,
      SCAN
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    idx_q, idx_d;
   logic [63:0]   shadow_q, shadow_d;
   logic          modeShadow_q, modeShadow_d;
   logic [7:0]    seg_q, seg_d;
   logic [7:0]    sel_q, sel_d;
   logic          frameDone_q, frameDone_d;
   logic          tick;
   logic          load;
   logic [7:0]    rawByte;
   logic [3:0]    nibble;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic [2:0]    msd_q, msd_d;
`endif

   function automatic logic [7:0] hexToSeg(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   function automatic logic [2:0] highestNibble(input logic [31:0] data);
      logic [2:0] msd;
      msd = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (data[4*k +: 4] != 4'h0) msd = 3'(k);
      end
      return msd;
   endfunction
`endif

   assign tick = (presc_q == PRESC_LAST);

   // Next-state logic: the shadow copy is refreshed only at frame start, and the decode
   // looks at the freshly loaded value so digit 0 of a new frame already shows new data.
   always_comb begin
      state_d      = state_q;
      presc_d      = tick ? '0 : presc_q + PW'(1);
      idx_d        = idx_q;
      shadow_d     = shadow_q;
      modeShadow_d = modeShadow_q;
      seg_d        = seg_q;
      sel_d        = sel_q;
      frameDone_d  = 1'b0;
      load         = 1'b0;
      rawByte      = 8'hFF;
      nibble       = 4'h0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      msd_d        = msd_q;
`endif

      case (state_q)
         BLANK: begin
            if (tick) begin
               load    = 1'b1;
               idx_d   = 3'd0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (tick) begin
               idx_d = idx_q + 3'd1;
               load  = (idx_q == 3'd7);
            end
         end
         default: state_d = BLANK;
      endcase

      if (load) begin
         shadow_d     = bus.i_data;
         modeShadow_d = bus.display_mode;
         frameDone_d  = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         msd_d        = highestNibble(bus.i_data[31:0]);
`endif
      end

      rawByte = shadow_d[{idx_d, 3'b000} +: 8];
      nibble  = shadow_d[{1'b0, idx_d, 2'b00} +: 4];

      if (tick) begin
         sel_d = ~(8'b1 << idx_d);
         if (modeShadow_d) begin
            seg_d = rawByte;
         end else begin
            seg_d = hexToSeg(nibble);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (idx_d > msd_d) seg_d = 8'hFF;
`endif
         end
      end
   end

   // All state, including the registered display outputs, goes dark asynchronously on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= BLANK;
         presc_q      <= '0;
         idx_q        <= 3'd0;
         shadow_q     <= 64'd0;
         modeShadow_q <= 1'b0;
         seg_q        <= 8'hFF;
         sel_q        <= 8'hFF;
         frameDone_q  <= 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         msd_q        <= 3'd0;
`endif
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         modeShadow_q <= modeShadow_d;
         seg_q        <= seg_d;
         sel_q        <= sel_d;
         frameDone_q  <= frameDone_d;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         msd_q        <= msd_d;
`endif
      end
   end

   assign bus.o_seg        = seg_q;
   assign bus.o_sel        = sel_q;
   assign bus.o_frame_done = frameDone_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with SCAN_DIV=4.
// Leading-zero expectations follow SEG7_LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_seg7_scan_driver;

   typedef logic [7:0] segArr_t [8];

   logic clk = 1'b0;
   logic reset;
   int   assertCount = 0;
   int   failCount = 0;

   seg7_scan_driver_if bus ();

   seg7_scan_driver #(.SCAN_DIV(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Hard stop in case the stimulus sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout, expected end of stimulus");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkDigit(input string tag, input logic [7:0] sel, input logic [7:0] seg, input logic fd);
      checkOutput({tag, ".sel"}, 64'(bus.o_sel), 64'(sel));
      checkOutput({tag, ".seg"}, 64'(bus.o_seg), 64'(seg));
      checkOutput({tag, ".fd"}, 64'(bus.o_frame_done), 64'(fd));
   endtask

   task automatic applyStimulus(input logic mode, input logic [63:0] data);
      bus.display_mode = mode;
      bus.i_data       = data;
   endtask

   task automatic stepSlot();
      repeat (4) @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [7:0] selFor(input int k);
      logic [7:0] s;
      s = 8'b1 << k;
      return ~s;
   endfunction

   // Steps through one whole frame from the digit-7 slot of the previous frame.
   task automatic scanFrame(input string tag, input segArr_t segs);
      for (int k = 0; k < 8; k++) begin
         stepSlot();
         checkDigit($sformatf("%s.d%0d", tag, k), selFor(k), segs[k], (k == 0));
      end
   endtask

   initial begin
      segArr_t hexSegs, rawSegs, oneSegs, lzSegs, zeroSegs;
      hexSegs = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
      rawSegs = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
      oneSegs = '{8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'hF9};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      lzSegs   = '{8'h92, 8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      zeroSegs = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
      lzSegs   = '{8'h92, 8'hC0, 8'h88, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
      zeroSegs = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif

      // Reset and the dark period before the first tick
      applyStimulus(1'b0, 64'h0000_0000_7654_3210);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkDigit("reset", 8'hFF, 8'hFF, 1'b0);
      reset = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         checkDigit($sformatf("blank.c%0d", c), 8'hFF, 8'hFF, 1'b0);
      end
      @(posedge clk);
      @(negedge clk);
      checkDigit("first.d0", 8'hFE, 8'hC0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("first.fdWidth", 64'(bus.o_frame_done), 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkDigit("hex.d1", selFor(1), hexSegs[1], 1'b0);
      for (int k = 2; k < 8; k++) begin
         stepSlot();
         checkDigit($sformatf("hex.d%0d", k), selFor(k), hexSegs[k], 1'b0);
      end
      stepSlot();
      checkDigit("wrap.d0", 8'hFE, 8'hC0, 1'b1);

      // Raw mode requested mid-frame: current frame stays hex
      applyStimulus(1'b1, 64'hFFFF_FFFE_FEFE_FEFE);
      for (int k = 1; k < 8; k++) begin
         stepSlot();
         checkDigit($sformatf("hold.d%0d", k), selFor(k), hexSegs[k], 1'b0);
      end
      scanFrame("raw", rawSegs);

      // Data change while digit 3 is displayed
      applyStimulus(1'b0, 64'h0000_0000_7654_3210);
      for (int k = 0; k < 8; k++) begin
         stepSlot();
         checkDigit($sformatf("mid.d%0d", k), selFor(k), hexSegs[k], (k == 0));
         if (k == 3) applyStimulus(1'b0, 64'h0000_0000_1111_1111);
      end
      scanFrame("next", oneSegs);

      // Leading zeros and an all-zero value
      applyStimulus(1'b0, 64'h0000_0000_0000_0A05);
      scanFrame("lz", lzSegs);
      applyStimulus(1'b0, 64'd0);
      scanFrame("zero", zeroSegs);

      // Asynchronous reset in the middle of digit 5
      applyStimulus(1'b0, 64'h0000_0000_7654_3210);
      for (int k = 0; k < 6; k++) begin
         stepSlot();
         checkDigit($sformatf("pre.d%0d", k), selFor(k), hexSegs[k], (k == 0));
      end
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkDigit("asyncReset", 8'hFF, 8'hFF, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         checkDigit($sformatf("restart.c%0d", c), 8'hFF, 8'hFF, 1'b0);
      end
      @(posedge clk);
      @(negedge clk);
      checkDigit("restart.d0", 8'hFE, 8'hC0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
